// File: rtl/simple_bus_pkg.sv
// simple_bus_pkg: shared types and helpers for the simple_bus memory slave.
//   bus_mode_e    - transfer mode encoding carried on the bus 'mode' lines
//   slave_state_e - slave sequencing states
//   is_burst()    - mode selects a multi-beat transfer
//   is_write()    - mode selects a write transfer
package simple_bus_pkg;

  typedef enum logic [1:0] {
    MODE_READ     = 2'b00,
    MODE_WRITE    = 2'b01,
    MODE_RD_BURST = 2'b10,
    MODE_WR_BURST = 2'b11
  } bus_mode_e;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    WAIT,
    BEAT
  } slave_state_e;

  function automatic logic is_burst(input bus_mode_e mode);
    return mode[1];
  endfunction

  function automatic logic is_write(input bus_mode_e mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/simple_bus_mem_slave_if.sv
// simple_bus_mem_slave_if: simple_bus handshake bundle.
//   req/start/mode/addr/wdata : master -> slave
//   gnt/rdata/rdy             : slave -> master
//   err                       : slave -> master, only when
//                               SIMPLE_BUS_MEM_SLAVE_ERR_EN is defined
interface simple_bus_mem_slave_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          req;
  logic          gnt;
  logic          start;
  logic [1:0]    mode;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          rdy;
`ifdef SIMPLE_BUS_MEM_SLAVE_ERR_EN
  logic          err;

  modport master (output req, start, mode, addr, wdata,
                  input  gnt, rdata, rdy, err);
  modport slave  (input  req, start, mode, addr, wdata,
                  output gnt, rdata, rdy, err);
`else
  modport master (output req, start, mode, addr, wdata,
                  input  gnt, rdata, rdy);
  modport slave  (input  req, start, mode, addr, wdata,
                  output gnt, rdata, rdy);
`endif
endinterface

// File: rtl/simple_bus_mem_array.sv
// simple_bus_mem_array: DEPTH x DW storage, no reset.
//   clk         : clock
//   we/waddr/wdata : synchronous write port
//   re/raddr/rdata : registered read port, rdata holds when re=0
// Callers keep addresses below DEPTH; only the low index bits are used.
module simple_bus_mem_array #(
  parameter int AW    = 8,
  parameter int DW    = 8,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr[IW-1:0]] <= wdata;
    if (re) rdata <= mem[raddr[IW-1:0]];
  end

endmodule

// File: rtl/simple_bus_mem_slave.sv
// simple_bus_mem_slave: RAM target on the simple_bus slave modport with
// configurable wait states and wrapping multi-beat bursts.
//   clk : bus clock
//   rst : asynchronous active-high reset
//   bus : simple_bus_mem_slave_if.slave (req/gnt/start/mode/addr/wdata/rdata/rdy[/err])
// Optional: SIMPLE_BUS_MEM_SLAVE_ERR_EN adds bus.err, flagged with rdy on
// every beat whose address is >= DEPTH.
//
// state | meaning
// IDLE  | bus not granted, waiting for req
// GRANT | gnt high, waiting for start (or req drop)
// WAIT  | wait-state countdown before a beat
// BEAT  | rdy high for one cycle, data transferred at cur_addr
module simple_bus_mem_slave
  import simple_bus_pkg::*;
#(
  parameter int AW          = 8,
  parameter int DW          = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0,
  parameter int BURST_LEN   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  simple_bus_mem_slave_if.slave  bus
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [3:0]  WS_W    = 4'(WAIT_STATES);
  localparam logic [4:0]  BL_W    = 5'(BURST_LEN);
  localparam bit          NO_WAIT = (WAIT_STATES == 0);

  slave_state_e  state_q, state_d;
  bus_mode_e     mode_q, mode_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [4:0]    beats_q, beats_d;
  logic [3:0]    wait_q, wait_d;
  logic          rd_ok_q;

  logic          mem_we, mem_re;
  logic [DW-1:0] mem_rdata;

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < DEPTH_W;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_READ;
      addr_q  <= '0;
      beats_q <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      beats_q <= beats_d;
      wait_q  <= wait_d;
    end
  end

  // The wait counter enters WAIT holding WAIT_STATES and reaches zero on the
  // edge into BEAT, so WAIT lasts exactly WAIT_STATES cycles; with no wait
  // states WAIT is skipped altogether.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    beats_d = beats_q;
    wait_d  = wait_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req) state_d = GRANT;
      end
      GRANT: begin
        if (bus.start) begin
          mode_d  = bus_mode_e'(bus.mode);
          addr_d  = bus.addr;
          beats_d = is_burst(mode_d) ? BL_W : 5'd1;
          wait_d  = WS_W;
          state_d = NO_WAIT ? BEAT : WAIT;
        end else if (!bus.req) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        wait_d = wait_q - 4'd1;
        if (wait_q == 4'd1) state_d = BEAT;
      end
      BEAT: begin
        if (beats_q != 5'd1) begin
          beats_d = beats_q - 5'd1;
          addr_d  = addr_q + AW'(1);
          wait_d  = WS_W;
          state_d = NO_WAIT ? BEAT : WAIT;
        end else begin
          beats_d = '0;
          state_d = bus.req ? GRANT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The read is launched on the edge into BEAT so the registered array output
  // is valid while rdy is high.
  assign mem_we = (state_q == BEAT) && is_write(mode_q) && in_range(addr_q);
  assign mem_re = (state_d == BEAT) && !is_write(mode_d) && in_range(addr_d);

  // Remembers whether the last read beat hit real storage; out-of-range reads
  // and reset both present zero without needing to reset the array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ok_q <= 1'b0;
    end else if ((state_d == BEAT) && !is_write(mode_d)) begin
      rd_ok_q <= in_range(addr_d);
    end
  end

  simple_bus_mem_array #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (addr_q),
    .wdata (bus.wdata),
    .re    (mem_re),
    .raddr (addr_d),
    .rdata (mem_rdata)
  );

  assign bus.gnt   = (state_q != IDLE);
  assign bus.rdy   = (state_q == BEAT);
  assign bus.rdata = rd_ok_q ? mem_rdata : '0;

`ifdef SIMPLE_BUS_MEM_SLAVE_ERR_EN
  assign bus.err = (state_q == BEAT) && !in_range(addr_q);
`endif

endmodule

// File: tb/tb_simple_bus_mem_slave.sv
// tb_simple_bus_mem_slave: two slave instances on one clock.
//   dut 0: DEPTH=256, WAIT_STATES=0
//   dut 1: DEPTH=128, WAIT_STATES=3
// err checks are compiled in with SIMPLE_BUS_MEM_SLAVE_ERR_EN.
module tb_simple_bus_mem_slave;

  logic       clk = 1'b0;
  logic       rst_v   [2];
  logic       req_v   [2];
  logic       start_v [2];
  logic [1:0] mode_v  [2];
  logic [7:0] addr_v  [2];
  logic [7:0] wdata_v [2];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ref_mem   [2][256];
  bit         ref_known [2][256];
  logic [7:0] last_rd   [2];
  bit         last_ok   [2];

  typedef struct packed {
    logic        dut;
    logic [1:0]  mode;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
    logic [3:0]  known;
    logic        keep;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  simple_bus_mem_slave_if #(.AW(8), .DW(8)) b0 ();
  simple_bus_mem_slave_if #(.AW(8), .DW(8)) b1 ();

  assign b0.req   = req_v[0];
  assign b0.start = start_v[0];
  assign b0.mode  = mode_v[0];
  assign b0.addr  = addr_v[0];
  assign b0.wdata = wdata_v[0];
  assign b1.req   = req_v[1];
  assign b1.start = start_v[1];
  assign b1.mode  = mode_v[1];
  assign b1.addr  = addr_v[1];
  assign b1.wdata = wdata_v[1];

  simple_bus_mem_slave #(
    .AW(8), .DW(8), .DEPTH(256), .WAIT_STATES(0), .BURST_LEN(4)
  ) dut0 (
    .clk (clk),
    .rst (rst_v[0]),
    .bus (b0)
  );

  simple_bus_mem_slave #(
    .AW(8), .DW(8), .DEPTH(128), .WAIT_STATES(3), .BURST_LEN(4)
  ) dut1 (
    .clk (clk),
    .rst (rst_v[1]),
    .bus (b1)
  );

  function automatic logic gnt_of(input int i);
    return (i == 0) ? b0.gnt : b1.gnt;
  endfunction

  function automatic logic rdy_of(input int i);
    return (i == 0) ? b0.rdy : b1.rdy;
  endfunction

  function automatic logic [7:0] rdata_of(input int i);
    return (i == 0) ? b0.rdata : b1.rdata;
  endfunction

`ifdef SIMPLE_BUS_MEM_SLAVE_ERR_EN
  function automatic logic err_of(input int i);
    return (i == 0) ? b0.err : b1.err;
  endfunction
`endif

  function automatic int depth_of(input int i);
    return (i == 0) ? 256 : 128;
  endfunction

  function automatic int ws_of(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One complete transaction on dut i. exp/known give per-beat read data.
  task automatic txn(input int i, input logic [1:0] m, input logic [7:0] a,
                     input logic [31:0] data, input logic [31:0] exp,
                     input logic [3:0] known, input logic keep);
    int         nb;
    int         k;
    logic       dropped;
    logic [7:0] ca;
    nb = m[1] ? 4 : 1;
    if (!gnt_of(i)) begin
      req_v[i] = 1'b1;
      @(posedge clk); #1;
      chk("gnt_latency", 32'(gnt_of(i)), 32'd1);
    end else begin
      req_v[i] = 1'b1;
    end
    start_v[i] = 1'b1;
    mode_v[i]  = m;
    addr_v[i]  = a;
    wdata_v[i] = data[7:0];
    @(posedge clk); #1;
    start_v[i] = 1'b0;
    mode_v[i]  = ~m;
    addr_v[i]  = ~a;
    for (int b = 0; b < nb; b++) begin
      ca = a + 8'(b);
      k = 0;
      dropped = 1'b0;
      while (!rdy_of(i) && k < 40) begin
        if (!gnt_of(i)) dropped = 1'b1;
        @(posedge clk); #1;
        k++;
      end
      chk("beat_latency", 32'(k), 32'(ws_of(i)));
      if (!rdy_of(i)) return;
      chk("gnt_held", 32'(dropped | !gnt_of(i)), 32'd0);
      if (!m[0]) begin
        if (known[b]) chk("rdata", 32'(rdata_of(i)), 32'(exp[8*b +: 8]));
        last_rd[i] = exp[8*b +: 8];
        last_ok[i] = known[b];
      end else if (int'(ca) < depth_of(i)) begin
        ref_mem[i][ca]   = data[8*b +: 8];
        ref_known[i][ca] = 1'b1;
      end
`ifdef SIMPLE_BUS_MEM_SLAVE_ERR_EN
      chk("err", 32'(err_of(i)), 32'(int'(ca) >= depth_of(i)));
`endif
      if (b == nb - 1) req_v[i] = keep;
      @(posedge clk); #1;
      if (b < nb - 1) wdata_v[i] = data[8*(b+1) +: 8];
    end
    chk("gnt_after", 32'(gnt_of(i)), 32'(keep));
    if (m[0] && last_ok[i]) chk("rdata_hold", 32'(rdata_of(i)), 32'(last_rd[i]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  m;
    logic [7:0]  a;
    logic [7:0]  ca;
    logic [31:0] d;
    logic [31:0] e;
    logic [3:0]  kn;
    int          i;
    int          k;
    int          nb;

    for (int j = 0; j < 2; j++) begin
      rst_v[j] = 1'b1; req_v[j] = 1'b0; start_v[j] = 1'b0;
      mode_v[j] = 2'b00; addr_v[j] = 8'h00; wdata_v[j] = 8'h00;
      last_rd[j] = 8'h00; last_ok[j] = 1'b1;
      for (int x = 0; x < 256; x++) begin
        ref_known[j][x] = 1'b0;
        ref_mem[j][x]   = 8'h00;
      end
    end

    vecs[0] = '{1'b0, 2'b01, 8'h10, 32'h000000A5, 32'h0,        4'h0, 1'b0};
    vecs[1] = '{1'b0, 2'b00, 8'h10, 32'h0,        32'h000000A5, 4'h1, 1'b0};
    vecs[2] = '{1'b0, 2'b11, 8'hFE, 32'h04030201, 32'h0,        4'h0, 1'b1};
    vecs[3] = '{1'b0, 2'b10, 8'hFE, 32'h0,        32'h04030201, 4'hF, 1'b0};
    vecs[4] = '{1'b1, 2'b01, 8'h90, 32'h00000055, 32'h0,        4'h0, 1'b0};
    vecs[5] = '{1'b1, 2'b00, 8'h90, 32'h0,        32'h00000000, 4'h1, 1'b0};
    vecs[6] = '{1'b1, 2'b01, 8'h40, 32'h0000003C, 32'h0,        4'h0, 1'b1};
    vecs[7] = '{1'b1, 2'b00, 8'h40, 32'h0,        32'h0000003C, 4'h1, 1'b0};
    vecs[8] = '{1'b1, 2'b11, 8'h7E, 32'h44332211, 32'h0,        4'h0, 1'b0};
    vecs[9] = '{1'b1, 2'b10, 8'h7E, 32'h0,        32'h00002211, 4'hF, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    rst_v[0] = 1'b0;
    rst_v[1] = 1'b0;

    for (int j = 0; j < 2; j++) begin
      chk("reset_gnt",   32'(gnt_of(j)),   32'd0);
      chk("reset_rdy",   32'(rdy_of(j)),   32'd0);
      chk("reset_rdata", 32'(rdata_of(j)), 32'd0);
`ifdef SIMPLE_BUS_MEM_SLAVE_ERR_EN
      chk("reset_err",   32'(err_of(j)),   32'd0);
`endif
    end

    for (int v = 0; v < 10; v++) begin
      txn(int'(vecs[v].dut), vecs[v].mode, vecs[v].addr, vecs[v].data,
          vecs[v].exp, vecs[v].known, vecs[v].keep);
    end

    // Reset during the WAIT of beat 2 of a write burst on the wait-state slave.
    txn(1, 2'b01, 8'h21, 32'h99, 32'h0, 4'h0, 1'b0);
    txn(1, 2'b01, 8'h20, 32'h98, 32'h0, 4'h0, 1'b0);
    req_v[1] = 1'b1;
    @(posedge clk); #1;
    start_v[1] = 1'b1; mode_v[1] = 2'b11; addr_v[1] = 8'h20; wdata_v[1] = 8'hC1;
    @(posedge clk); #1;
    start_v[1] = 1'b0;
    k = 0;
    while (!rdy_of(1) && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("rst_seq_beat1_latency", 32'(k), 32'd3);
    req_v[1] = 1'b0;
    @(posedge clk); #1;
    wdata_v[1] = 8'hC2;
    @(posedge clk); #1;
    rst_v[1] = 1'b1;
    #1;
    chk("rst_mid_gnt",   32'(gnt_of(1)),   32'd0);
    chk("rst_mid_rdy",   32'(rdy_of(1)),   32'd0);
    chk("rst_mid_rdata", 32'(rdata_of(1)), 32'd0);
    @(posedge clk); #1;
    rst_v[1] = 1'b0;
    ref_mem[1][8'h20] = 8'hC1;
    last_rd[1] = 8'h00;
    last_ok[1] = 1'b1;
    txn(1, 2'b00, 8'h21, 32'h0, 32'h99, 4'h1, 1'b0);
    txn(1, 2'b00, 8'h20, 32'h0, 32'hC1, 4'h1, 1'b0);

    // Randomized transactions against the reference memories.
    for (int r = 0; r < 40; r++) begin
      i  = int'($urandom_range(0, 1));
      m  = 2'($urandom_range(0, 3));
      a  = (i == 0) ? 8'($urandom_range(32'hF8, 32'h107))
                    : 8'($urandom_range(32'h70, 32'h97));
      d  = $urandom;
      e  = 32'h0;
      kn = 4'h0;
      nb = m[1] ? 4 : 1;
      if (!m[0]) begin
        for (int b = 0; b < nb; b++) begin
          ca = a + 8'(b);
          if (int'(ca) >= depth_of(i)) begin
            e[8*b +: 8] = 8'h00;
            kn[b] = 1'b1;
          end else if (ref_known[i][ca]) begin
            e[8*b +: 8] = ref_mem[i][ca];
            kn[b] = 1'b1;
          end
        end
      end
      txn(i, m, a, d, e, kn, 1'($urandom_range(0, 1)));
    end

    req_v[0] = 1'b0;
    req_v[1] = 1'b0;
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
